// File: rtl/truxton2_pcm_rom_server_pkg.sv
// Shared sound-path definitions for the PCM sample-ROM server: address widths,
// FSM state encoding, debug view and line-geometry helpers.
package truxton2_pcm_rom_server_pkg;

    localparam int PCM_AW = 20;
    localparam int SDR_AW = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } pcm_state_t;

    // Debug view of the controller; cnt is wide enough for the largest line.
    typedef struct packed {
        pcm_state_t state;
        logic       valid;
        logic [4:0] cnt;
    } pcm_dbg_t;

    // Bits needed to index a word inside a line.
    function automatic int word_idx_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    // Bits of byte offset inside a line (LB = 2 * line_words bytes).
    function automatic int off_bits(input int line_words);
        return $clog2(line_words) + 1;
    endfunction

    // Remaining upper address bits form the line tag.
    function automatic int tag_bits(input int line_words);
        return PCM_AW - off_bits(line_words);
    endfunction

endpackage

// File: rtl/truxton2_pcm_rom_server_if.sv
// Bus bundle between the ADPCM engine / SDRAM arbiter side (master) and the
// PCM ROM server (slave).
// Handshakes: SDR_REQ is raised by the server and held with SDR_ADDR stable
// until a one-cycle SDR_ACK is sampled; each one-cycle SDR_DST carries one
// SDR_DATA word. PCM_OK qualifies PCM_DOUT for the PCM_ADDR currently driven.
interface truxton2_pcm_rom_server_if;
    import truxton2_pcm_rom_server_pkg::*;

    logic              PCM_CS;
    logic [PCM_AW-1:0] PCM_ADDR;
    logic [7:0]        PCM_DOUT;
    logic              PCM_OK;
    logic              SDR_REQ;
    logic [SDR_AW-1:0] SDR_ADDR;
    logic              SDR_ACK;
    logic              SDR_DST;
    logic [15:0]       SDR_DATA;

    modport master (
        output PCM_CS, PCM_ADDR, SDR_ACK, SDR_DST, SDR_DATA,
        input  PCM_DOUT, PCM_OK, SDR_REQ, SDR_ADDR
    );

    modport slave (
        input  PCM_CS, PCM_ADDR, SDR_ACK, SDR_DST, SDR_DATA,
        output PCM_DOUT, PCM_OK, SDR_REQ, SDR_ADDR
    );

endinterface

// File: rtl/truxton2_pcm_rom_server_pcm_line_buf.sv
// One-line sample buffer: LINE_WORDS 16-bit words, the line tag and a valid
// flag. Written word by word during a burst, read as little-endian bytes.
module truxton2_pcm_rom_server_pcm_line_buf
    import truxton2_pcm_rom_server_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    localparam int WI = word_idx_bits(LINE_WORDS),
    localparam int OB = off_bits(LINE_WORDS),
    localparam int TW = tag_bits(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_valid,
    input  logic          set_valid,
    input  logic          tag_we,
    input  logic [TW-1:0] tag_in,
    input  logic          wr_en,
    input  logic [WI-1:0] wr_idx,
    input  logic [15:0]   wr_data,
    input  logic [OB-1:0] rd_off,
    output logic [7:0]    rd_byte,
    output logic [TW-1:0] tag_q,
    output logic          valid_q
);

    logic [15:0] mem [LINE_WORDS];
    logic [15:0] rd_word;

    // Word storage; contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Tag and valid; clearing on a new request wins over a completing fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (tag_we) begin
                tag_q <= tag_in;
            end
            if (clr_valid) begin
                valid_q <= 1'b0;
            end else if (set_valid) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign rd_word = mem[rd_off[OB-1:1]];
    assign rd_byte = rd_off[0] ? rd_word[15:8] : rd_word[7:0];

endmodule

// File: rtl/truxton2_pcm_rom_server.sv
// PCM sample-ROM server: answers ADPCM byte reads from a one-line buffer and
// refills the line with an SDRAM burst on a miss.
module truxton2_pcm_rom_server
    import truxton2_pcm_rom_server_pkg::*;
#(
    parameter int                LINE_WORDS = 4,
    parameter logic [SDR_AW-1:0] BASE       = '0
) (
    input  logic                     CLK96,
    input  logic                     RESET96,
    truxton2_pcm_rom_server_if.slave bus,
    output pcm_dbg_t                 dbg
);

    localparam int WI = word_idx_bits(LINE_WORDS);
    localparam int OB = off_bits(LINE_WORDS);
    localparam int TW = tag_bits(LINE_WORDS);
    localparam logic [WI-1:0] CNT_LAST = WI'(LINE_WORDS - 1);

    pcm_state_t        state_q, state_d;
    logic [WI-1:0]     cnt_q, cnt_d;
    logic              req_q, req_d;
    logic [SDR_AW-1:0] sdr_addr_q;
    logic [7:0]        dout_q;
    logic              ok_q;
    logic [PCM_AW-1:0] srv_addr_q;

    logic [TW-1:0]     cur_tag;
    logic [OB-1:0]     cur_off;
    logic [TW-1:0]     buf_tag;
    logic              buf_valid;
    logic [7:0]        buf_byte;
    logic              hit;

    logic              start_req;
    logic              fill_wr;
    logic              set_valid;
    logic              hit_load;

    assign cur_tag = bus.PCM_ADDR[PCM_AW-1:OB];
    assign cur_off = bus.PCM_ADDR[OB-1:0];
    assign hit     = buf_valid && (buf_tag == cur_tag);

    truxton2_pcm_rom_server_pcm_line_buf #(
        .LINE_WORDS(LINE_WORDS)
    ) u_line_buf (
        .clk       (CLK96),
        .rst       (RESET96),
        .clr_valid (start_req),
        .set_valid (set_valid),
        .tag_we    (start_req),
        .tag_in    (cur_tag),
        .wr_en     (fill_wr),
        .wr_idx    (cnt_q),
        .wr_data   (bus.SDR_DATA),
        .rd_off    (cur_off),
        .rd_byte   (buf_byte),
        .tag_q     (buf_tag),
        .valid_q   (buf_valid)
    );

    // Next-state and control strobes; ACK/DST outside their states fall through unused.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        start_req = 1'b0;
        fill_wr   = 1'b0;
        set_valid = 1'b0;
        hit_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    hit_load = 1'b1;
                end else if (bus.PCM_CS) begin
                    start_req = 1'b1;
                    req_d     = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (bus.SDR_ACK) begin
                    req_d   = 1'b0;
                    state_d = FILL;
                    // A strobe coincident with the ACK is word 0 (cnt_q is 0 here).
                    if (bus.SDR_DST) begin
                        fill_wr = 1'b1;
                        cnt_d   = WI'(1);
                    end
                end
            end
            FILL: begin
                if (bus.SDR_DST) begin
                    fill_wr = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        set_valid = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + WI'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, burst request/address and served-byte registers.
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            sdr_addr_q <= BASE;
            dout_q     <= 8'h00;
            ok_q       <= 1'b0;
            srv_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ok_q    <= hit_load;
            if (start_req) begin
                sdr_addr_q <= BASE + (SDR_AW'(cur_tag) << WI);
            end
            if (hit_load) begin
                dout_q     <= buf_byte;
                srv_addr_q <= bus.PCM_ADDR;
            end
        end
    end

    assign bus.PCM_DOUT = dout_q;
    // Combinational address match so OK drops the same cycle the address moves.
    assign bus.PCM_OK   = ok_q && (srv_addr_q == bus.PCM_ADDR);
    assign bus.SDR_REQ  = req_q;
    assign bus.SDR_ADDR = sdr_addr_q;

    assign dbg.state = state_q;
    assign dbg.valid = buf_valid;
    assign dbg.cnt   = 5'(cnt_q);

endmodule

// File: tb/tb_truxton2_pcm_rom_server.sv
// Directed bench for the PCM ROM server with LINE_WORDS=4, BASE=0.
module tb_truxton2_pcm_rom_server;
    import truxton2_pcm_rom_server_pkg::*;

    logic     CLK96;
    logic     RESET96;
    pcm_dbg_t dbg;
    int       n_checks;
    int       n_errors;
    logic     saw_req;
    logic [7:0] exp_stream [8];

    truxton2_pcm_rom_server_if bus ();

    truxton2_pcm_rom_server #(
        .LINE_WORDS(4),
        .BASE      (22'h0)
    ) dut (
        .CLK96   (CLK96),
        .RESET96 (RESET96),
        .bus     (bus),
        .dbg     (dbg)
    );

    // Clock and watchdog.
    initial begin
        CLK96 = 1'b0;
        forever #5 CLK96 = ~CLK96;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge CLK96);
        #1;
    endtask

    task automatic sdr_ack();
        bus.SDR_ACK = 1'b1;
        tick();
        bus.SDR_ACK = 1'b0;
    endtask

    task automatic sdr_strobe(input logic [15:0] w);
        bus.SDR_DST  = 1'b1;
        bus.SDR_DATA = w;
        tick();
        bus.SDR_DST  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_stream[0] = 8'h00; exp_stream[1] = 8'h11;
        exp_stream[2] = 8'h22; exp_stream[3] = 8'h33;
        exp_stream[4] = 8'h44; exp_stream[5] = 8'h55;
        exp_stream[6] = 8'h66; exp_stream[7] = 8'h77;

        RESET96      = 1'b1;
        bus.PCM_CS   = 1'b0;
        bus.PCM_ADDR = 20'h0;
        bus.SDR_ACK  = 1'b0;
        bus.SDR_DST  = 1'b0;
        bus.SDR_DATA = 16'h0;
        repeat (3) tick();
        RESET96 = 1'b0;

        // Reset values.
        check("rst_dout",  32'(bus.PCM_DOUT), 32'h00);
        check("rst_ok",    32'(bus.PCM_OK), 32'h0);
        check("rst_req",   32'(bus.SDR_REQ), 32'h0);
        check("rst_addr",  32'(bus.SDR_ADDR), 32'h0);
        check("rst_valid", 32'(dbg.valid), 32'h0);
        check("rst_state", 32'(dbg.state), 32'(IDLE));

        // Cold miss at 0x13: request at N+1, line 2 -> word address 8.
        bus.PCM_CS   = 1'b1;
        bus.PCM_ADDR = 20'h00013;
        #1;
        check("cold_req_pre", 32'(bus.SDR_REQ), 32'h0);
        tick();
        check("cold_req",   32'(bus.SDR_REQ), 32'h1);
        check("cold_addr",  32'(bus.SDR_ADDR), 32'h8);
        check("cold_state", 32'(dbg.state), 32'(REQ));
        for (int i = 0; i < 2; i++) begin
            tick();
            check("cold_req_hold",  32'(bus.SDR_REQ), 32'h1);
            check("cold_addr_hold", 32'(bus.SDR_ADDR), 32'h8);
        end
        sdr_ack();
        check("cold_req_drop", 32'(bus.SDR_REQ), 32'h0);
        check("cold_fill",     32'(dbg.state), 32'(FILL));
        sdr_strobe(16'h1100);
        sdr_strobe(16'h3322);
        sdr_strobe(16'h5544);
        sdr_strobe(16'h7766);
        check("cold_ok_early", 32'(bus.PCM_OK), 32'h0);
        check("cold_valid",    32'(dbg.valid), 32'h1);
        tick();
        check("cold_ok",   32'(bus.PCM_OK), 32'h1);
        check("cold_dout", 32'(bus.PCM_DOUT), 32'h33);

        // Hit streaming, one byte per cycle.
        for (int i = 0; i < 8; i++) begin
            bus.PCM_ADDR = 20'h10 + 20'(i);
            tick();
            check("stream_dout", 32'(bus.PCM_DOUT), 32'(exp_stream[i]));
            check("stream_ok",   32'(bus.PCM_OK), 32'h1);
            check("stream_req",  32'(bus.SDR_REQ), 32'h0);
        end

        // Stale-OK guard.
        bus.PCM_ADDR = 20'h10;
        tick();
        check("stale_ok_base", 32'(bus.PCM_OK), 32'h1);
        bus.PCM_ADDR = 20'h11;
        #1;
        check("stale_ok_drop", 32'(bus.PCM_OK), 32'h0);
        tick();
        check("stale_ok_back", 32'(bus.PCM_OK), 32'h1);
        check("stale_dout",    32'(bus.PCM_DOUT), 32'h11);

        // ACK and DST outside REQ/FILL are ignored.
        bus.SDR_ACK  = 1'b1;
        bus.SDR_DST  = 1'b1;
        bus.SDR_DATA = 16'hFFFF;
        tick();
        bus.SDR_ACK = 1'b0;
        bus.SDR_DST = 1'b0;
        check("stray_state", 32'(dbg.state), 32'(IDLE));
        check("stray_req",   32'(bus.SDR_REQ), 32'h0);
        bus.PCM_ADDR = 20'h10;
        tick();
        check("stray_word0", 32'(bus.PCM_DOUT), 32'h00);

        // Address change mid-fill: line 0x40 completes, then line 0x100 is requested.
        bus.PCM_ADDR = 20'h00040;
        tick();
        check("mid_req",  32'(bus.SDR_REQ), 32'h1);
        check("mid_addr", 32'(bus.SDR_ADDR), 32'h20);
        sdr_ack();
        sdr_strobe(16'hAAAA);
        sdr_strobe(16'hBBBB);
        bus.PCM_ADDR = 20'h00100;
        #1;
        check("mid_ok_a", 32'(bus.PCM_OK), 32'h0);
        sdr_strobe(16'hCCCC);
        check("mid_ok_b", 32'(bus.PCM_OK), 32'h0);
        sdr_strobe(16'hDDDD);
        check("mid_idle",   32'(dbg.state), 32'(IDLE));
        check("mid_req_lo", 32'(bus.SDR_REQ), 32'h0);
        check("mid_ok_c",   32'(bus.PCM_OK), 32'h0);
        tick();
        check("mid_req2",  32'(bus.SDR_REQ), 32'h1);
        check("mid_addr2", 32'(bus.SDR_ADDR), 32'h80);
        check("mid_ok_d",  32'(bus.PCM_OK), 32'h0);
        // ACK together with the first strobe: strobe lands in word 0.
        bus.SDR_ACK  = 1'b1;
        bus.SDR_DST  = 1'b1;
        bus.SDR_DATA = 16'hBEEF;
        tick();
        bus.SDR_ACK = 1'b0;
        bus.SDR_DST = 1'b0;
        check("ackdst_req",   32'(bus.SDR_REQ), 32'h0);
        check("ackdst_state", 32'(dbg.state), 32'(FILL));
        check("ackdst_cnt",   32'(dbg.cnt), 32'h1);
        sdr_strobe(16'h1234);
        sdr_strobe(16'h5678);
        sdr_strobe(16'h9ABC);
        check("mid_ok_e", 32'(bus.PCM_OK), 32'h0);
        tick();
        check("mid_ok2",   32'(bus.PCM_OK), 32'h1);
        check("mid_dout2", 32'(bus.PCM_DOUT), 32'hEF);

        // CS low: hits still served, misses do not request.
        bus.PCM_CS   = 1'b0;
        bus.PCM_ADDR = 20'h00101;
        tick();
        check("cslo_hit_dout", 32'(bus.PCM_DOUT), 32'hBE);
        check("cslo_hit_ok",   32'(bus.PCM_OK), 32'h1);
        bus.PCM_ADDR = 20'h00106;
        tick();
        check("cslo_hit_dout3", 32'(bus.PCM_DOUT), 32'hBC);
        bus.PCM_ADDR = 20'h00200;
        saw_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.SDR_REQ) saw_req = 1'b1;
        end
        check("cslo_no_req", 32'(saw_req), 32'h0);
        check("cslo_ok",     32'(bus.PCM_OK), 32'h0);
        bus.PCM_CS = 1'b1;
        #1;
        check("cshi_req_pre", 32'(bus.SDR_REQ), 32'h0);
        tick();
        check("cshi_req",  32'(bus.SDR_REQ), 32'h1);
        check("cshi_addr", 32'(bus.SDR_ADDR), 32'h100);

        // Reset during FILL after one strobe, then stray strobes.
        sdr_ack();
        sdr_strobe(16'h0102);
        check("rf_cnt1",  32'(dbg.cnt), 32'h1);
        check("rf_state", 32'(dbg.state), 32'(FILL));
        bus.PCM_CS = 1'b0;
        RESET96    = 1'b1;
        tick();
        RESET96 = 1'b0;
        check("rf_req",   32'(bus.SDR_REQ), 32'h0);
        check("rf_ok",    32'(bus.PCM_OK), 32'h0);
        check("rf_valid", 32'(dbg.valid), 32'h0);
        check("rf_idle",  32'(dbg.state), 32'(IDLE));
        check("rf_cnt0",  32'(dbg.cnt), 32'h0);
        check("rf_dout",  32'(bus.PCM_DOUT), 32'h00);
        for (int i = 0; i < 3; i++) begin
            sdr_strobe(16'hDEAD);
        end
        check("stray_cnt",   32'(dbg.cnt), 32'h0);
        check("stray_idle",  32'(dbg.state), 32'(IDLE));
        check("stray_valid", 32'(dbg.valid), 32'h0);
        bus.PCM_CS = 1'b1;
        tick();
        check("rr_req",  32'(bus.SDR_REQ), 32'h1);
        check("rr_addr", 32'(bus.SDR_ADDR), 32'h100);
        sdr_ack();
        sdr_strobe(16'h2211);
        sdr_strobe(16'h4433);
        sdr_strobe(16'h6655);
        check("rr_valid3", 32'(dbg.valid), 32'h0);
        check("rr_fill3",  32'(dbg.state), 32'(FILL));
        sdr_strobe(16'h8877);
        check("rr_valid4", 32'(dbg.valid), 32'h1);
        tick();
        check("rr_dout0", 32'(bus.PCM_DOUT), 32'h11);
        check("rr_ok0",   32'(bus.PCM_OK), 32'h1);
        bus.PCM_ADDR = 20'h00207;
        tick();
        check("rr_dout7", 32'(bus.PCM_DOUT), 32'h88);
        check("rr_ok7",   32'(bus.PCM_OK), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
